// File: rtl/code_check_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : code_check_arbiter
//  Purpose  : Round-robin sharing of one external 6-bit code checker among
//             N_REQ requesters. Statistics counters are built in only when
//             the CHECK_STATS_EN macro is defined.
//  Revision : 1.0
// ============================================================================
module code_check_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
`ifdef CHECK_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                 clock,
    input  logic                 reset_L,
    input  logic [N_REQ-1:0]     req,
    input  logic [6*N_REQ-1:0]   code,
    output logic [N_REQ-1:0]     ack,
    output logic                 result,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic [5:0]           chk_code,
    input  logic                 chk_valid
`ifdef CHECK_STATS_EN
    ,
    input  logic                 clear_stats,
    output logic [CNT_W-1:0]     accept_cnt,
    output logic [CNT_W-1:0]     reject_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [ID_W-1:0] c_last_id = ID_W'(N_REQ - 1);

    state_t           r_state;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [5:0]       w_code_arr [N_REQ];
    logic [ID_W-1:0]  w_winner;
    logic             w_any;
    logic [ID_W-1:0]  w_next_ptr;

    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
            assign w_code_arr[g] = code[6*g +: 6];
        end
    endgenerate

    // First active request at or above rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_any && req[(int'(r_rr_ptr) + i) % N_REQ]) begin
                w_any    = 1'b1;
                w_winner = ID_W'((int'(r_rr_ptr) + i) % N_REQ);
            end
        end
    end

    assign w_next_ptr = (grant_id == c_last_id) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            ack      <= '0;
            result   <= 1'b0;
            grant_id <= '0;
            busy     <= 1'b0;
            chk_code <= 6'b000000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        grant_id <= w_winner;
                        chk_code <= w_code_arr[w_winner];
                        busy     <= 1'b1;
                        r_state  <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // chk_code has been stable for the whole cycle here.
                    result  <= chk_valid;
                    ack     <= N_REQ'(1) << grant_id;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    ack      <= '0;
                    busy     <= 1'b0;
                    r_rr_ptr <= w_next_ptr;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    ack     <= '0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CHECK_STATS_EN
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            accept_cnt <= '0;
            reject_cnt <= '0;
        end else if (clear_stats) begin
            accept_cnt <= '0;
            reject_cnt <= '0;
        end else if (r_state == ST_RESP) begin
            if (result) begin
                if (accept_cnt != '1) accept_cnt <= accept_cnt + 1'b1;
            end else begin
                if (reject_cnt != '1) reject_cnt <= reject_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_code_check_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_code_check_arbiter
//  Purpose  : Directed bench with a transaction-level reference model.
//  Revision : 1.0
// ============================================================================
module tb_code_check_arbiter;
    localparam int NR = 4;
    localparam int IW = 2;
`ifdef CHECK_STATS_EN
    localparam int CW = 16;
`endif

    logic              clock = 1'b0;
    logic              reset_L;
    logic [NR-1:0]     req;
    logic [6*NR-1:0]   code;
    logic [NR-1:0]     ack;
    logic              result;
    logic [IW-1:0]     grant_id;
    logic              busy;
    logic [5:0]        chk_code;
    logic              chk_valid;
`ifdef CHECK_STATS_EN
    logic              clear_stats;
    logic [CW-1:0]     accept_cnt, reject_cnt;
    logic [NR-1:0]     req2, ack2;
    logic [6*NR-1:0]   code2;
    logic              result2, busy2, chk_valid2;
    logic [IW-1:0]     grant_id2;
    logic [5:0]        chk_code2;
    logic [1:0]        accept_cnt2, reject_cnt2;
`endif

    always #5 clock = ~clock;

    assign chk_valid = (chk_code == 6'h00) || (chk_code == 6'h2A);

    code_check_arbiter #(
        .N_REQ(NR)
`ifdef CHECK_STATS_EN
        , .CNT_W(CW)
`endif
    ) dut (
        .clock(clock), .reset_L(reset_L), .req(req), .code(code),
        .ack(ack), .result(result), .grant_id(grant_id), .busy(busy),
        .chk_code(chk_code), .chk_valid(chk_valid)
`ifdef CHECK_STATS_EN
        , .clear_stats(clear_stats), .accept_cnt(accept_cnt), .reject_cnt(reject_cnt)
`endif
    );

`ifdef CHECK_STATS_EN
    assign chk_valid2 = (chk_code2 == 6'h00) || (chk_code2 == 6'h2A);

    code_check_arbiter #(.N_REQ(NR), .CNT_W(2)) dut2 (
        .clock(clock), .reset_L(reset_L), .req(req2), .code(code2),
        .ack(ack2), .result(result2), .grant_id(grant_id2), .busy(busy2),
        .chk_code(chk_code2), .chk_valid(chk_valid2),
        .clear_stats(1'b0), .accept_cnt(accept_cnt2), .reject_cnt(reject_cnt2)
    );
`endif

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_check(input logic [5:0] c);
        return (c == 6'h00) || (c == 6'h2A);
    endfunction

    function automatic int rr_pick(input int ptr, input logic [NR-1:0] r);
        for (int i = 0; i < NR; i++)
            if (r[(ptr + i) % NR]) return (ptr + i) % NR;
        return 0;
    endfunction

    function automatic int onehot_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    // Transaction model: a grant at edge s yields an ack in the cycle after
    // edge s+1 and frees the checker at edge s+2.
    int         ecount   = 0;
    bit         m_active = 0;
    int         m_start  = 0;
    int         m_win    = 0;
    logic [5:0] m_chk    = '0;
    bit         m_res    = 0;
    int         m_ptr    = 0;
    int         m_acc    = 0;
    int         m_rej    = 0;

    always @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            m_active = 0; m_win = 0; m_chk = '0; m_res = 0; m_ptr = 0;
            m_acc = 0; m_rej = 0;
        end else begin
            ecount++;
            if (m_active && ecount == m_start + 2) begin
                m_ptr    = (m_win + 1) % NR;
                m_active = 0;
`ifdef CHECK_STATS_EN
                if (m_res) m_acc = (m_acc == (1 << CW) - 1) ? m_acc : m_acc + 1;
                else       m_rej = (m_rej == (1 << CW) - 1) ? m_rej : m_rej + 1;
`endif
            end else if (!m_active && req != '0) begin
                m_win    = rr_pick(m_ptr, req);
                m_chk    = code[6*m_win +: 6];
                m_res    = ref_check(m_chk);
                m_start  = ecount;
                m_active = 1;
            end
`ifdef CHECK_STATS_EN
            if (clear_stats) begin
                m_acc = 0;
                m_rej = 0;
            end
`endif
        end
    end

    always @(negedge clock) begin
        logic [NR-1:0] e_ack;
        e_ack = (m_active && ecount == m_start + 1) ? (NR'(1) << m_win) : '0;
        check("cyc_ack", 32'(ack), 32'(e_ack));
        check("cyc_busy", 32'(busy), 32'(m_active));
        check("cyc_grant_id", 32'(grant_id), 32'(m_win));
        check("cyc_chk_code", 32'(chk_code), 32'(m_chk));
        if (e_ack != '0) check("cyc_result", 32'(result), 32'(m_res));
`ifdef CHECK_STATS_EN
        check("cyc_accept_cnt", 32'(accept_cnt), 32'(m_acc));
        check("cyc_reject_cnt", 32'(reject_cnt), 32'(m_rej));
`endif
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic serve(input int idx, input logic [5:0] c);
        code[6*idx +: 6] = c;
        req = NR'(1) << idx;
        tick(); tick(); tick();
        req = '0;
    endtask

    int q_id[$];
    int q_res[$];
    int q_edge[$];
    int exp_order[5];
    int exp_res[5];
    int n_ack;

    initial begin
        req = '0;
        code = '0;
        reset_L = 1'b0;
`ifdef CHECK_STATS_EN
        clear_stats = 1'b0;
        req2 = '0;
        code2 = '0;
`endif
        repeat (3) tick();
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_chk_code", 32'(chk_code), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        check("rst_result", 32'(result), 32'h0);
        reset_L = 1'b1;
        tick();

        // Single requester, valid then invalid code.
        code[5:0] = 6'h00;
        req = 4'b0001;
        tick();
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_ack_early", 32'(ack), 32'h0);
        check("t1_chk_code", 32'(chk_code), 32'h00);
        tick();
        check("t1_ack", 32'(ack), 32'h1);
        check("t1_result", 32'(result), 32'h1);
        check("t1_grant_id", 32'(grant_id), 32'h0);
        tick();
        req = '0;
        check("t1_idle", 32'(busy), 32'h0);
        code[5:0] = 6'h15;
        req = 4'b0001;
        tick(); tick();
        check("t1b_ack", 32'(ack), 32'h1);
        check("t1b_result", 32'(result), 32'h0);
        tick();
        req = '0;

        // All four requesting continuously from rr_ptr = 0.
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
        code = {6'h3F, 6'h00, 6'h01, 6'h2A};
        req = 4'b1111;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (ack != '0) begin
                q_id.push_back(onehot_idx(ack));
                q_res.push_back(int'(result));
                q_edge.push_back(ecount);
            end
        end
        req = '0;
        exp_order = '{0, 1, 2, 3, 0};
        exp_res   = '{1, 0, 1, 0, 1};
        check("t3_ack_count", 32'(q_id.size()), 32'd5);
        if (q_id.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check("t3_order", 32'(q_id[i]), 32'(exp_order[i]));
                check("t3_result", 32'(q_res[i]), 32'(exp_res[i]));
                if (i > 0) check("t3_spacing", 32'(q_edge[i] - q_edge[i-1]), 32'd3);
            end
        end

        // Wrap-around: after serving requester 1, requester 0 beats 1.
        serve(1, 6'h01);
        code[5:0]  = 6'h2A;
        code[11:6] = 6'h00;
        req = 4'b0011;
        q_id.delete();
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack != '0) q_id.push_back(onehot_idx(ack));
        end
        req = '0;
        check("t4_ack_count", 32'(q_id.size()), 32'd2);
        if (q_id.size() == 2) begin
            check("t4_first", 32'(q_id[0]), 32'd0);
            check("t4_second", 32'(q_id[1]), 32'd1);
        end

        // Code change and req drop after the grant are ignored.
        code[5:0] = 6'h00;
        req = 4'b0001;
        tick();
        code[5:0] = 6'h3F;
        req = '0;
        tick();
        check("t5_ack", 32'(ack), 32'h1);
        check("t5_result", 32'(result), 32'h1);
        n_ack = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack != '0) n_ack++;
        end
        check("t5_ack_once", 32'(n_ack), 32'd1);

        // Reset in the middle of a transaction.
        code[17:12] = 6'h2A;
        req = 4'b0100;
        tick();
        check("t6_busy_pre", 32'(busy), 32'h1);
        #2 reset_L = 1'b0;
        #1;
        check("t6_rst_ack", 32'(ack), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_chk", 32'(chk_code), 32'h0);
        tick();
        reset_L = 1'b1;
        tick();
        check("t6_busy", 32'(busy), 32'h1);
        check("t6_grant_id", 32'(grant_id), 32'h2);
        tick();
        check("t6_ack", 32'(ack), 32'h4);
        check("t6_result", 32'(result), 32'h1);
        tick();
        req = '0;

`ifdef CHECK_STATS_EN
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        serve(0, 6'h00);
        serve(1, 6'h2A);
        serve(2, 6'h00);
        serve(0, 6'h01);
        serve(3, 6'h3F);
        check("st_accept", 32'(accept_cnt), 32'd3);
        check("st_reject", 32'(reject_cnt), 32'd2);
        code[5:0] = 6'h00;
        req = 4'b0001;
        tick(); tick();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        req = '0;
        check("st_clr_accept", 32'(accept_cnt), 32'd0);
        check("st_clr_reject", 32'(reject_cnt), 32'd0);
        code2 = '0;
        req2 = 4'b0001;
        repeat (15) tick();
        req2 = '0;
        check("st_sat_accept", 32'(accept_cnt2), 32'd3);
        check("st_sat_reject", 32'(reject_cnt2), 32'd0);
`endif

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
